message_schedule: RTL and testbench

MESSAGE_SCHEDULE -- requirements
Module: message_schedule

---
 rtl/message_schedule.sv | 122 ++++++++++++
 tb/tb_message_schedule.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/message_schedule.sv
// rtl/message_schedule.sv - SHA-256 message schedule generator streaming W[0..63] from a 16-word circular window
// Define SCHED_STALL_EN to honour W_READY back-pressure; otherwise one word is transferred every RUN cycle.
module message_schedule (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [15:0][31:0] BLOCK,
    input  logic             W_READY,
    output logic [31:0]      W_OUT,
    output logic             W_VALID,
    output logic [5:0]       T,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] win [16];
    logic [3:0]  ptr;
    logic        done_q;
    logic        ready_eff;
    logic        accept;
    logic        xfer;
    logic        last;
    logic [3:0]  idx_m16;
    logic [3:0]  idx_m15;
    logic [3:0]  idx_m7;
    logic [3:0]  idx_m2;
    logic [31:0] w_new;
    logic [31:0] next_word;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

`ifdef SCHED_STALL_EN
    assign ready_eff = W_READY;
`else
    logic unused_ready;
    assign unused_ready = W_READY;
    assign ready_eff    = 1'b1;
`endif

    assign accept = (state == IDLE) && START;
    assign xfer   = (state == RUN) && ready_eff;
    assign last   = (T == 6'd63);

    // ptr tracks T mod 16; the slot after it holds W[n-16] for the next round n = T+1
    assign idx_m16 = ptr + 4'd1;
    assign idx_m15 = ptr + 4'd2;
    assign idx_m7  = ptr + 4'd10;
    assign idx_m2  = ptr + 4'd15;

    assign w_new     = sig1(win[idx_m2]) + win[idx_m7] + sig0(win[idx_m15]) + win[idx_m16];
    assign next_word = (T >= 6'd15) ? w_new : win[idx_m16];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (START) state_next = RUN;
            RUN:     if (xfer && last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        BUSY    = (state == RUN);
        W_VALID = (state == RUN);
        DONE    = done_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            T      <= 6'd0;
            ptr    <= 4'd0;
            W_OUT  <= 32'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= xfer && last;
            if (accept) begin
                T     <= 6'd0;
                ptr   <= 4'd0;
                W_OUT <= BLOCK[0];
            end else if (xfer) begin
                if (last) begin
                    T   <= 6'd0;
                    ptr <= 4'd0;
                end else begin
                    T     <= T + 6'd1;
                    ptr   <= ptr + 4'd1;
                    W_OUT <= next_word;
                end
            end
        end
    end

    // Window contents are don't-care until a START loads them
    always_ff @(posedge CLK) begin
        if (accept) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= BLOCK[i];
            end
        end else if (xfer && !last && (T >= 6'd15)) begin
            win[idx_m16] <= w_new;
        end
    end

endmodule

// File: tb/tb_message_schedule.sv
// tb/tb_message_schedule.sv - directed self-checking bench for message_schedule
module tb_message_schedule;

`ifdef SCHED_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [15:0][31:0] block;
    logic             w_ready;
    logic [31:0]      w_out;
    logic             w_valid;
    logic [5:0]       t;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    message_schedule dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .START   (start),
        .BLOCK   (block),
        .W_READY (w_ready),
        .W_OUT   (w_out),
        .W_VALID (w_valid),
        .T       (t),
        .BUSY    (busy),
        .DONE    (done)
    );

    typedef struct {
        int          t;
        logic [31:0] w;
    } spot_t;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] ref_w [64];
    logic [31:0] obs_w [64];
    logic [15:0][31:0] blk_abc;
    logic [15:0][31:0] blk_zero;
    logic [15:0][31:0] blk_alt;
    spot_t       spots [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic build_ref(input logic [15:0][31:0] blk);
        logic [31:0] s0;
        logic [31:0] s1;
        for (int i = 0; i < 16; i++) ref_w[i] = blk[i];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(ref_w[i-15], 7) ^ rotr(ref_w[i-15], 18) ^ (ref_w[i-15] >> 3);
            s1 = rotr(ref_w[i-2], 17) ^ rotr(ref_w[i-2], 19) ^ (ref_w[i-2] >> 10);
            ref_w[i] = s1 + ref_w[i-7] + s0 + ref_w[i-16];
        end
    endtask

    // mode: 0 ready held 1, 1 ready toggles 1,0,0,1, 2 ready held 0.
    // Returns at the negedge on which DONE is observed high.
    task automatic run_block(input logic [15:0][31:0] blk, input int mode,
                             input int repulse_t, input logic [15:0][31:0] alt);
        int exp_t, valid_cnt, cyc, done_cyc, p;
        bit fin, full, pulsed, rdy_eff;
        build_ref(blk);
        block     = blk;
        start     = 1'b1;
        w_ready   = (mode == 0);
        exp_t     = 0;
        valid_cnt = 0;
        done_cyc  = 0;
        fin       = 1'b0;
        full      = 1'b1;
        pulsed    = 1'b0;
        p         = 0;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!fin && cyc < 400) begin
            if (done) begin
                check("done_after_t63", exp_t, 64);
                check("valid_clear_at_done", w_valid, 1'b0);
                check("busy_clear_at_done", busy, 1'b0);
                done_cyc = cyc;
                fin      = 1'b1;
            end else begin
                check("valid_in_run", w_valid, 1'b1);
                check("busy_in_run", busy, 1'b1);
                if (w_valid) begin
                    valid_cnt++;
                    check("t_index", t, exp_t);
                    check("w_word", w_out, ref_w[exp_t[5:0]]);
                    obs_w[exp_t[5:0]] = w_out;
                end
                if (repulse_t >= 0 && !pulsed && exp_t == repulse_t) begin
                    start  = 1'b1;
                    block  = alt;
                    pulsed = 1'b1;
                end else begin
                    start = 1'b0;
                end
                case (mode)
                    0:       w_ready = 1'b1;
                    1:       w_ready = ((p % 4) == 0) || ((p % 4) == 3);
                    default: w_ready = 1'b0;
                endcase
                p++;
                rdy_eff = STALL ? w_ready : 1'b1;
                if (!rdy_eff) full = 1'b0;
                if (w_valid && rdy_eff) exp_t++;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        if (!fin) check("run_timeout", 32'd1, 32'd0);
        if (full) begin
            check("valid_cycles", valid_cnt, 64);
            check("done_cycle", done_cyc, 65);
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("idle_valid", w_valid, 1'b0);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        w_ready = 1'b1;
        blk_abc  = '0;
        blk_zero = '0;
        blk_abc[0]  = 32'h61626380;
        blk_abc[15] = 32'h00000018;
        for (int i = 0; i < 16; i++) blk_alt[i] = 32'h01010101 * (i + 1);
        block = blk_zero;
        spots[0] = '{0,  32'h61626380};
        spots[1] = '{1,  32'h00000000};
        spots[2] = '{14, 32'h00000000};
        spots[3] = '{15, 32'h00000018};
        spots[4] = '{16, 32'h61626380};
        spots[5] = '{17, 32'h000F0000};

        @(negedge clk);
        @(negedge clk);
        check("rst_valid", w_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_t", t, 6'd0);
        check("rst_wout", w_out, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", w_valid, 1'b0);

        run_block(blk_abc, 0, -1, blk_zero);
        for (int i = 0; i < 6; i++) check("abc_spot", obs_w[spots[i].t], spots[i].w);
        idle_check();

        run_block(blk_zero, 0, -1, blk_zero);
        idle_check();

        run_block(blk_abc, 1, -1, blk_zero);
        idle_check();

        run_block(blk_abc, 0, 20, blk_alt);
        check("chain_done_cycle", done, 1'b1);
        run_block(blk_alt, 0, -1, blk_zero);
        idle_check();

        block   = blk_abc;
        start   = 1'b1;
        w_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && !(w_valid && t == 6'd30); i++) @(negedge clk);
        check("pre_reset_t30", t, 6'd30);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", w_valid, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_t", t, 6'd0);
        check("async_rst_wout", w_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_run_without_start", w_valid, 1'b0);
        end
        run_block(blk_abc, 0, -1, blk_zero);
        idle_check();

`ifndef SCHED_STALL_EN
        run_block(blk_abc, 2, -1, blk_zero);
        idle_check();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
